// File: rtl/spi_master_if.sv
// spi_master_if: system handshake (start/tx_data/busy/done/rx_data) plus SPI pins of one master link.
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, tx_data, MISO,
        output busy, done, rx_data, SCLK, SS, MOSI
    );

    modport slave (
        output start, tx_data, MISO,
        input  busy, done, rx_data, SCLK, SS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI master, 12 SCLK cycles per SS-low window, framed by SETUP/HOLD/GAP.
// Optional macro SPI_MASTER_LOOPBACK_EN adds an lpbk input that feeds scheduled MOSI bits back as rx.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic lpbk,
`endif
    spi_master_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [3:0]       LAST_CYC  = 4'd11;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       cyc_q, cyc_d;
    logic             sclk_q, sclk_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             sample;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lpbk_q, lpbk_d;
    // The bit being launched on MOSI at a fall is exactly the rx bit due at that fall.
    assign sample = lpbk_q ? tx_sh_q[7] : bus.MISO;
`else
    assign sample = bus.MISO;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cyc_d     = cyc_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
`ifdef SPI_MASTER_LOOPBACK_EN
        lpbk_d    = lpbk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    tx_sh_d = bus.tx_data;
                    busy_d  = 1'b1;
                    ss_d    = 1'b0;
                    div_d   = '0;
                    cyc_d   = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
                    lpbk_d  = lpbk;
`endif
                end
            end
            SETUP: begin
                if (div_q == HALF_LAST) begin
                    state_d = XFER;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            XFER: begin
                if (div_q != HALF_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling transition ending cycle k: sample rx and launch the bit for k+1.
                        sclk_d = 1'b0;
                        if (cyc_q >= 4'd2 && cyc_q <= 4'd9) begin
                            mosi_d  = tx_sh_q[7];
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                            rx_sh_d = {rx_sh_q[6:0], sample};
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else if (cyc_q == LAST_CYC) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        cyc_d  = cyc_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (div_q == HALF_LAST) begin
                    state_d   = GAP;
                    ss_d      = 1'b1;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    div_d     = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_q == GAP_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cyc_q     <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= 8'h00;
`ifdef SPI_MASTER_LOOPBACK_EN
            lpbk_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cyc_q     <= cyc_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lpbk_q    <= lpbk_d;
`endif
        end
    end

    // Shift registers carry pure data; every frame reloads or fully refills them.
    always_ff @(posedge clk) begin
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

    assign bus.SCLK    = sclk_q;
    assign bus.SS      = ss_q;
    assign bus.MOSI    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with CLK_DIV=2 and CLK_DIV=1 instances and a behavioural SPI slave.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if if0 ();
    spi_master_if if1 ();

    logic       start_r;
    logic [7:0] tx_r;
    logic       miso_r;
    logic       sel1;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       lpbk_r;
`endif

    assign if0.start   = start_r & ~sel1;
    assign if1.start   = start_r & sel1;
    assign if0.tx_data = tx_r;
    assign if1.tx_data = tx_r;
    assign if0.MISO    = miso_r;
    assign if1.MISO    = miso_r;

    spi_master #(.CLK_DIV(2)) dut0 (
        .clk (clk),
        .rst (rst),
`ifdef SPI_MASTER_LOOPBACK_EN
        .lpbk(lpbk_r),
`endif
        .bus (if0.master)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef SPI_MASTER_LOOPBACK_EN
        .lpbk(lpbk_r),
`endif
        .bus (if1.master)
    );

    logic       o_sclk, o_ss, o_mosi, o_busy, o_done;
    logic [7:0] o_rx;
    assign o_sclk = sel1 ? if1.SCLK    : if0.SCLK;
    assign o_ss   = sel1 ? if1.SS      : if0.SS;
    assign o_mosi = sel1 ? if1.MOSI    : if0.MOSI;
    assign o_busy = sel1 ? if1.busy    : if0.busy;
    assign o_done = sel1 ? if1.done    : if0.done;
    assign o_rx   = sel1 ? if1.rx_data : if0.rx_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int ss_rise_cyc = 0;
    int gap_last    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One frame against a slave model that counts SCLK rises: rise k returns reply bit 9-k (k=2..9)
    // and records MOSI as bit 10-k (k=3..10). Timing expectations are in clocks after acceptance edge T.
    task automatic run_frame(input logic [7:0] tx, input logic [7:0] reply, input logic [7:0] exp_rx,
                             input bit hold, input logic [7:0] next_tx, input string tag);
        int d;
        int n, idx, rises, first_rise, done_at, done_cnt, ss_bad;
        logic [7:0] slave_rx;
        logic sclk_prev;
        d = sel1 ? 1 : 2;
        n = 0;
        while (o_busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s idle before start", tag), o_busy, 1'b0);
        start_r = 1'b1;
        tx_r    = tx;
        miso_r  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        gap_last = cyc - ss_rise_cyc;
        chk($sformatf("%s busy after accept", tag), o_busy, 1'b1);
        if (!hold) start_r = 1'b0;
        tx_r = next_tx;
        idx = 0; rises = 0; first_rise = -1; done_at = -1; done_cnt = 0; ss_bad = 0;
        slave_rx = 8'h00; sclk_prev = 1'b0;
        while (o_busy === 1'b1 && idx <= 40 * d) begin
            if (o_sclk === 1'b1 && sclk_prev === 1'b0) begin
                if (rises == 0) first_rise = idx;
                if (o_ss !== 1'b0) ss_bad++;
                if (rises >= 3 && rises <= 10) slave_rx[10 - rises] = o_mosi;
                miso_r = (rises >= 2 && rises <= 9) ? reply[9 - rises] : 1'b0;
                rises++;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_at = idx;
                chk($sformatf("%s rx at done", tag), o_rx, exp_rx);
            end
            if ((idx < 26 * d) == (o_ss === 1'b1)) ss_bad++;
            if (idx == 26 * d) ss_rise_cyc = cyc;
            sclk_prev = o_sclk;
            @(negedge clk);
            idx++;
        end
        miso_r = 1'b0;
        chk($sformatf("%s sclk rises", tag), rises, 12);
        chk($sformatf("%s first rise", tag), first_rise, d);
        chk($sformatf("%s done time", tag), done_at, 26 * d);
        chk($sformatf("%s done pulses", tag), done_cnt, 1);
        chk($sformatf("%s slave rx", tag), slave_rx, tx);
        chk($sformatf("%s busy low time", tag), idx, 28 * d);
        chk($sformatf("%s ss window", tag), ss_bad, 0);
        chk($sformatf("%s rx held", tag), o_rx, exp_rx);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] reply;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int bad, n, rises, dn;
        logic sclk_prev;
        logic [7:0] t, r;

        vecs[0] = '{tx: 8'hA5, reply: 8'h3C, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h00, reply: 8'hFF, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, reply: 8'h00, exp_rx: 8'h00};
        vecs[3] = '{tx: 8'h80, reply: 8'h01, exp_rx: 8'h01};
        vecs[4] = '{tx: 8'h69, reply: 8'h96, exp_rx: 8'h96};

        rst = 1'b1; start_r = 1'b0; tx_r = 8'h00; miso_r = 1'b0; sel1 = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        lpbk_r = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_ss !== 1'b1 || o_sclk !== 1'b0 || o_mosi !== 1'b0 || o_busy !== 1'b0 ||
                o_done !== 1'b0 || o_rx !== 8'h00) bad++;
        end
        chk("reset idle window", bad, 0);
        chk("reset ss", o_ss, 1'b1);
        chk("reset rx_data", o_rx, 8'h00);

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].tx, vecs[i].reply, vecs[i].exp_rx, 1'b0, ~vecs[i].tx,
                      $sformatf("vec%0d", i));

        // Back-to-back with start held high; tx_data changes during frame one.
        run_frame(8'h01, 8'h5C, 8'h5C, 1'b1, 8'hFF, "b2b0");
        run_frame(8'hFF, 8'hE7, 8'hE7, 1'b0, 8'h00, "b2b1");
        chk("b2b ss high gap", gap_last, 5);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_busy !== 1'b0) bad++;
        end
        chk("b2b no third frame", bad, 0);

        // Reset during SCLK cycle 6.
        start_r = 1'b1; tx_r = 8'h77;
        @(posedge clk);
        @(negedge clk);
        start_r = 1'b0;
        n = 0; rises = 0; sclk_prev = 1'b0;
        while (rises < 7 && n < 200) begin
            if (o_sclk === 1'b1 && sclk_prev === 1'b0) rises++;
            sclk_prev = o_sclk;
            if (rises < 7) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midrst reached cycle 6", rises, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst ss", o_ss, 1'b1);
        chk("midrst sclk", o_sclk, 1'b0);
        chk("midrst busy", o_busy, 1'b0);
        chk("midrst mosi", o_mosi, 1'b0);
        chk("midrst rx", o_rx, 8'h00);
        rst = 1'b0;
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) dn++;
        end
        chk("midrst no done", dn, 0);
        run_frame(8'h5A, 8'hC3, 8'hC3, 1'b0, 8'h00, "after rst");

        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            r = 8'($urandom);
            run_frame(t, r, r, 1'b0, 8'($urandom), $sformatf("rand%0d", i));
        end

        // CLK_DIV=1 instance.
        sel1 = 1'b1;
        run_frame(8'h80, 8'h4B, 8'h4B, 1'b0, 8'h7F, "div1 80");
        for (int i = 0; i < 4; i++) begin
            t = 8'($urandom);
            r = 8'($urandom);
            run_frame(t, r, r, 1'b0, 8'($urandom), $sformatf("div1 rand%0d", i));
        end
        sel1 = 1'b0;

`ifdef SPI_MASTER_LOOPBACK_EN
        lpbk_r = 1'b1;
        run_frame(8'hC3, 8'h00, 8'hC3, 1'b0, 8'h00, "lpbk on");
        lpbk_r = 1'b0;
        run_frame(8'hC3, 8'h00, 8'h00, 1'b0, 8'h00, "lpbk off");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
